// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: synchronised RX pin, start-bit qualification,
// 2-of-3 mid-bit voting, configurable frame format, valid/ready word delivery.
module uart_rx_ovs #(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int MID = BAUD_DIV / 2;
  localparam int TW  = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] T_MID_LO = TW'(MID - 1);
  localparam logic [TW-1:0] T_MID    = TW'(MID);
  localparam logic [TW-1:0] T_VOTE   = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_reg, state_next;
  logic                   sync1_reg, sync2_reg, prev_reg;
  logic [TW-1:0]          timer_reg, timer_next;
  logic [3:0]             bit_idx_reg, bit_idx_next;
  logic [1:0]             samp_reg, samp_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   perr_reg, perr_next;
  logic                   ferr_reg, ferr_next;
  logic                   vote, at_vote, at_wrap, deliver, deliver_ferr;

  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   rx_valid_reg, parity_err_reg, frame_err_reg, overrun_reg;

  assign vote    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & sync2_reg) | (samp_reg[1] & sync2_reg);
  assign at_vote = (timer_reg == T_VOTE);
  assign at_wrap = (timer_reg == T_LAST);
  assign deliver_ferr = ferr_reg | ~vote;

  // prev exists only for falling-edge detection on the synchronised line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= uart_rx_data;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      samp_reg    <= 2'b11;
      shift_reg   <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      samp_reg    <= samp_next;
      shift_reg   <= shift_next;
      perr_reg    <= perr_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = at_wrap ? '0 : timer_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    samp_next    = samp_reg;
    shift_next   = shift_reg;
    perr_next    = perr_reg;
    ferr_next    = ferr_reg;
    deliver      = 1'b0;
    if (timer_reg == T_MID_LO) samp_next[0] = sync2_reg;
    if (timer_reg == T_MID)    samp_next[1] = sync2_reg;
    case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        if (prev_reg && !sync2_reg) begin
          state_next = S_START;
          perr_next  = 1'b0;
          ferr_next  = 1'b0;
        end
      end
      S_START: begin
        if (at_vote && vote) begin
          state_next = S_IDLE;
          timer_next = '0;
        end else if (at_wrap) begin
          state_next   = S_DATA;
          bit_idx_next = '0;
        end
      end
      S_DATA: begin
        if (at_vote) shift_next = {vote, shift_reg[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (bit_idx_reg == LAST_DATA) begin
            bit_idx_next = '0;
            state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (at_vote) perr_next = vote ^ (^shift_reg) ^ ODD_PAR;
        if (at_wrap) begin
          state_next   = S_STOP;
          bit_idx_next = '0;
        end
      end
      S_STOP: begin
        // Last stop bit finishes at its vote so a back-to-back start is caught
        if (at_vote) begin
          ferr_next = deliver_ferr;
          if (bit_idx_reg == LAST_STOP) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
            timer_next = '0;
          end
        end else if (at_wrap) begin
          bit_idx_next = bit_idx_reg + 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (deliver) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg    <= shift_reg;
          parity_err_reg <= perr_reg;
          frame_err_reg  <= deliver_ferr;
          rx_valid_reg   <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: an 8N1 and a 7E1 instance, both at 16 clk/bit.
module tb_uart_rx_ovs;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

  int checks = 0;
  int passed = 0;
  int acc_a = 0, acc_b = 0, ovr_cnt_a = 0;
  logic [7:0] last_data_a;
  logic [6:0] last_data_b;
  logic       last_perr_a, last_ferr_a, last_perr_b, last_ferr_b;

  always #5 clk = ~clk;

  uart_rx_ovs #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .uart_rx_data(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .rx_busy(busy_a)
  );

  uart_rx_ovs #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .uart_rx_data(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .rx_busy(busy_b)
  );

  // Record every accepted word and every overrun pulse
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      acc_a       <= acc_a + 1;
      last_data_a <= data_a;
      last_perr_a <= perr_a;
      last_ferr_a <= ferr_a;
    end
    if (valid_b && ready_b) begin
      acc_b       <= acc_b + 1;
      last_data_b <= data_b;
      last_perr_b <= perr_b;
      last_ferr_b <= ferr_b;
    end
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input bit to_b, input logic v);
    if (to_b) rx_b = v; else rx_a = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit to_b, input logic [8:0] data, input int nbits,
                            input bit has_par, input bit par_bit, input bit stop_bit,
                            input int gap_bits);
    drive_bit(to_b, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(to_b, data[i]);
    if (has_par) drive_bit(to_b, par_bit);
    drive_bit(to_b, stop_bit);
    for (int i = 0; i < gap_bits; i++) drive_bit(to_b, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data",   {24'd0, data_a}, 32'h0);
    chk("reset_valid",  {31'd0, valid_a}, 32'h0);
    chk("reset_perr",   {31'd0, perr_a}, 32'h0);
    chk("reset_ferr",   {31'd0, ferr_a}, 32'h0);
    chk("reset_ovr",    {31'd0, ovr_a}, 32'h0);
    chk("reset_busy",   {31'd0, busy_a}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 8N1 0xA5, consumer always ready: exactly one accepted cycle
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 2);
    chk("a5_count", acc_a, 32'd1);
    chk("a5_data",  {24'd0, last_data_a}, 32'hA5);
    chk("a5_perr",  {31'd0, last_perr_a}, 32'h0);
    chk("a5_ferr",  {31'd0, last_ferr_a}, 32'h0);
    chk("a5_busy",  {31'd0, busy_a}, 32'h0);
    chk("a5_valid", {31'd0, valid_a}, 32'h0);

    // 7E1 0x53 has four ones, so the correct even parity bit is 0
    send_frame(1'b1, 9'h053, 7, 1'b1, 1'b1, 1'b1, 2);
    chk("par_bad_count", acc_b, 32'd1);
    chk("par_bad_data",  {25'd0, last_data_b}, 32'h53);
    chk("par_bad_perr",  {31'd0, last_perr_b}, 32'h1);
    chk("par_bad_ferr",  {31'd0, last_ferr_b}, 32'h0);
    send_frame(1'b1, 9'h053, 7, 1'b1, 1'b0, 1'b1, 2);
    chk("par_ok_count", acc_b, 32'd2);
    chk("par_ok_data",  {25'd0, last_data_b}, 32'h53);
    chk("par_ok_perr",  {31'd0, last_perr_b}, 32'h0);

    // Stop bit low still delivers, with frame error
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 2);
    chk("ferr_count", acc_a, 32'd2);
    chk("ferr_data",  {24'd0, last_data_a}, 32'h3C);
    chk("ferr_flag",  {31'd0, last_ferr_a}, 32'h1);
    send_frame(1'b0, 9'h00F, 8, 1'b0, 1'b0, 1'b1, 2);
    chk("good_count", acc_a, 32'd3);
    chk("good_data",  {24'd0, last_data_a}, 32'h0F);
    chk("good_ferr",  {31'd0, last_ferr_a}, 32'h0);

    // 4-clk glitch: start detected, then rejected at the vote
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_a = 1'b1;
    @(posedge clk);
    #1;
    chk("glitch_busy_hi", {31'd0, busy_a}, 32'h1);
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_busy_lo", {31'd0, busy_a}, 32'h0);
    chk("glitch_count",   acc_a, 32'd3);
    send_frame(1'b0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 2);
    chk("post_glitch_count", acc_a, 32'd4);
    chk("post_glitch_data",  {24'd0, last_data_a}, 32'h81);

    // Stalled consumer, back-to-back frames: second word dropped
    ready_a = 1'b0;
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 0);
    send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 2);
    chk("ovr_valid", {31'd0, valid_a}, 32'h1);
    chk("ovr_data",  {24'd0, data_a}, 32'h11);
    chk("ovr_pulses", ovr_cnt_a, 32'd1);
    chk("ovr_count", acc_a, 32'd4);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_valid", {31'd0, valid_a}, 32'h0);
    chk("accept_hold",  {24'd0, data_a}, 32'h11);
    chk("accept_count", acc_a, 32'd5);
    chk("accept_word",  {24'd0, last_data_a}, 32'h11);

    // Reset in the middle of 0xFF's data bits
    rx_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_busy_pre", {31'd0, busy_a}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_data",  {24'd0, data_a}, 32'h0);
    chk("midrst_valid", {31'd0, valid_a}, 32'h0);
    chk("midrst_busy",  {31'd0, busy_a}, 32'h0);
    chk("midrst_ferr",  {31'd0, ferr_a}, 32'h0);
    chk("midrst_ovr",   {31'd0, ovr_a}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_nodeliver", acc_a, 32'd5);
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 2);
    chk("post_rst_count", acc_a, 32'd6);
    chk("post_rst_data",  {24'd0, last_data_a}, 32'h5A);
    chk("post_rst_ferr",  {31'd0, last_ferr_a}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
